cacheline_adapter: RTL and testbench

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter_pkg.sv | 18 +
 rtl/cacheline_adapter_stats.sv | 21 ++
 rtl/cacheline_adapter.sv | 135 +++++++++++++
 tb/tb_cacheline_adapter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared types and defaults for the cache-line <-> memory burst adapter.
package cacheline_adapter_pkg;

    localparam int BURST_W_DEF = 64;
    localparam int BURSTS_DEF  = 4;
    localparam int LINE_W_DEF  = BURST_W_DEF * BURSTS_DEF;

    typedef logic [BURST_W_DEF-1:0] burst_t;
    typedef logic [LINE_W_DEF-1:0]  line_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/cacheline_adapter_stats.sv
// Completed-transaction counters for the cache-line adapter; both wrap at 2^32.
module cacheline_adapter_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_done,
    input  logic        wr_done,
    output logic [31:0] rd_count_o,
    output logic [31:0] wr_count_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else begin
            if (rd_done) rd_count_o <= rd_count_o + 32'd1;
            if (wr_done) wr_count_o <= wr_count_o + 32'd1;
        end
    end

endmodule

// File: rtl/cacheline_adapter.sv
// Splits a cache-line read/write into BURSTS memory beats and reassembles reads.
// Optional transaction counters are built when CACHELINE_ADAPTER_STATS_EN is defined.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
#(
    parameter int BURST_W = BURST_W_DEF,
    parameter int BURSTS  = BURSTS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BURST_W*BURSTS-1:0]   line_i,
    output logic [BURST_W*BURSTS-1:0]   line_o,
    input  logic [31:0]                 address_i,
    input  logic                        read_i,
    input  logic                        write_i,
    output logic                        resp_o,
    input  logic [BURST_W-1:0]          burst_i,
    output logic [BURST_W-1:0]          burst_o,
    output logic [31:0]                 address_o,
    output logic                        read_o,
    output logic                        write_o,
    input  logic                        resp_i,
    output logic [31:0]                 rd_count_o,
    output logic [31:0]                 wr_count_o
);

    // state | meaning
    // IDLE  | waiting for a cache request; write has priority over read
    // READ  | collecting BURSTS beats from memory into line_o
    // WRITE | presenting latched line to memory one beat at a time
    // DONE  | one-cycle resp_o pulse back to the cache

    localparam int          LINE_W    = BURST_W * BURSTS;
    localparam int          BEAT_W    = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFE0;

    state_t              state;
    logic [BEAT_W-1:0]   beat;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [31:0]         addr_q;
    logic                last_beat;

    assign last_beat = (beat == BEAT_W'(BURSTS - 1));
    assign line_o    = line_q;
    assign address_o = addr_q;
    assign burst_o   = wdata_q[int'(beat)*BURST_W +: BURST_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            beat    <= '0;
            line_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            read_o  <= 1'b0;
            write_o <= 1'b0;
            resp_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i) begin
                        wdata_q <= line_i;
                        addr_q  <= address_i & ADDR_MASK;
                        beat    <= '0;
                        write_o <= 1'b1;
                        state   <= WRITE;
                    end else if (read_i) begin
                        addr_q  <= address_i & ADDR_MASK;
                        beat    <= '0;
                        read_o  <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_q[int'(beat)*BURST_W +: BURST_W] <= burst_i;
                        if (last_beat) begin
                            beat   <= '0;
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        if (last_beat) begin
                            beat    <= '0;
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                DONE: begin
                    resp_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    read_o  <= 1'b0;
                    write_o <= 1'b0;
                    resp_o  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHELINE_ADAPTER_STATS_EN
    logic rd_done;
    logic wr_done;

    // Pulses on the edge that enters DONE, so counts update together with resp_o.
    assign rd_done = (state == READ)  && resp_i && last_beat;
    assign wr_done = (state == WRITE) && resp_i && last_beat;

    cacheline_adapter_stats u_stats (
        .clk        (clk),
        .rst        (rst),
        .rd_done    (rd_done),
        .wr_done    (wr_done),
        .rd_count_o (rd_count_o),
        .wr_count_o (wr_count_o)
    );
`else
    assign rd_count_o = '0;
    assign wr_count_o = '0;
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed vector table, mid-read reset, random traffic.
module tb_cacheline_adapter;

    localparam int          BURST_W = 64;
    localparam int          BURSTS  = 4;
    localparam int          LINE_W  = BURST_W * BURSTS;
    localparam logic [31:0] AMASK   = 32'hFFFF_FFE0;
`ifdef CACHELINE_ADAPTER_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [LINE_W-1:0] line_i, line_o;
    logic [31:0]       address_i, address_o;
    logic              read_i, write_i, resp_o;
    logic [BURST_W-1:0] burst_i, burst_o;
    logic              read_o, write_o, resp_i;
    logic [31:0]       rd_count_o, wr_count_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: last line delivered to the cache, completion counts, memory contents.
    logic [LINE_W-1:0] exp_line = '0;
    int unsigned       exp_rd = 0;
    int unsigned       exp_wr = 0;
    logic [LINE_W-1:0] mem [logic [31:0]];

    typedef struct {
        bit                is_wr;
        bit                both;
        logic [31:0]       addr;
        logic [LINE_W-1:0] data;
        int                gap;
        logic [31:0]       exp_addr;
    } vec_t;

    vec_t vecs [5];

    cacheline_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .line_i     (line_i),
        .line_o     (line_o),
        .address_i  (address_i),
        .read_i     (read_i),
        .write_i    (write_i),
        .resp_o     (resp_o),
        .burst_i    (burst_i),
        .burst_o    (burst_o),
        .address_o  (address_o),
        .read_o     (read_o),
        .write_o    (write_o),
        .resp_i     (resp_i),
        .rd_count_o (rd_count_o),
        .wr_count_o (wr_count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tally(input string name, input bit ok, input string act, input string exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        tally(name, act === exp, $sformatf("%b", act), $sformatf("%b", exp));
    endtask

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        tally(name, act === exp, $sformatf("%0h", act), $sformatf("%0h", exp));
    endtask

    task automatic check_d(input string name, input logic [BURST_W-1:0] act, input logic [BURST_W-1:0] exp);
        tally(name, act === exp, $sformatf("%0h", act), $sformatf("%0h", exp));
    endtask

    task automatic check_l(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        tally(name, act === exp, $sformatf("%0h", act), $sformatf("%0h", exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        check_w({tag, " rd_count"}, rd_count_o, STATS_EN ? exp_rd : 32'd0);
        check_w({tag, " wr_count"}, wr_count_o, STATS_EN ? exp_wr : 32'd0);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [BURST_W-1:0] rand_burst();
        return {$urandom, $urandom};
    endfunction

    // resp_i during DONE and the following IDLE cycle must not disturb anything.
    task automatic stray_resp_and_release(input logic [LINE_W-1:0] line_exp);
        resp_i  = 1'b1;
        burst_i = rand_burst();
        step();
        check_b("done resp_o falls", resp_o, 1'b0);
        read_i  = 1'b0;
        write_i = 1'b0;
        step();
        resp_i = 1'b0;
        check_b("idle read_o", read_o, 1'b0);
        check_b("idle write_o", write_o, 1'b0);
        check_l("line_o held", line_o, line_exp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [LINE_W-1:0] data,
                           input int gap, input logic [31:0] a_exp);
        int n;
        read_i    = 1'b1;
        write_i   = 1'b0;
        address_i = addr;
        step();
        n = cyc;
        check_b("rd read_o up", read_o, 1'b1);
        check_b("rd write_o", write_o, 1'b0);
        check_w("rd address_o", address_o, a_exp);
        address_i = ~addr;
        step();
        for (int b = 0; b < BURSTS; b++) begin
            for (int g = 0; g < gap; g++) begin
                resp_i  = 1'b0;
                burst_i = rand_burst();
                step();
                check_b("rd gap read_o", read_o, 1'b1);
                check_w("rd gap address_o", address_o, a_exp);
                check_b("rd gap resp_o", resp_o, 1'b0);
            end
            resp_i  = 1'b1;
            burst_i = data[b*BURST_W +: BURST_W];
            step();
            resp_i  = 1'b0;
            burst_i = rand_burst();
            if (b < BURSTS - 1) check_b("rd mid read_o", read_o, 1'b1);
        end
        exp_line = data;
        exp_rd++;
        check_b("rd resp_o", resp_o, 1'b1);
        check_b("rd read_o down", read_o, 1'b0);
        check_l("rd line_o", line_o, exp_line);
        check_w("rd address_o end", address_o, a_exp);
        check_stats("rd");
        if (gap == 0) check_w("rd latency", 32'(cyc - n), 32'd5);
        stray_resp_and_release(exp_line);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [LINE_W-1:0] data,
                            input int gap, input bit both, input logic [31:0] a_exp);
        int n;
        write_i   = 1'b1;
        read_i    = both;
        address_i = addr;
        line_i    = data;
        step();
        n = cyc;
        check_b("wr write_o up", write_o, 1'b1);
        check_b("wr read_o", read_o, 1'b0);
        check_w("wr address_o", address_o, a_exp);
        address_i = ~addr;
        line_i    = ~data;
        step();
        for (int b = 0; b < BURSTS; b++) begin
            for (int g = 0; g < gap; g++) begin
                resp_i = 1'b0;
                check_d("wr gap burst_o", burst_o, data[b*BURST_W +: BURST_W]);
                step();
                check_b("wr gap write_o", write_o, 1'b1);
                check_b("wr gap read_o", read_o, 1'b0);
            end
            check_d("wr burst_o", burst_o, data[b*BURST_W +: BURST_W]);
            resp_i = 1'b1;
            step();
            resp_i = 1'b0;
            if (b < BURSTS - 1) check_b("wr mid write_o", write_o, 1'b1);
        end
        mem[a_exp] = data;
        exp_wr++;
        check_b("wr resp_o", resp_o, 1'b1);
        check_b("wr write_o down", write_o, 1'b0);
        check_b("wr read_o end", read_o, 1'b0);
        check_l("wr line_o untouched", line_o, exp_line);
        check_stats("wr");
        if (gap == 0) check_w("wr latency", 32'(cyc - n), 32'd5);
        stray_resp_and_release(exp_line);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_1234,
                    {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 32'h0000_1220};
        vecs[1] = '{1'b1, 1'b0, 32'h8000_0040,
                    {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 0, 32'h8000_0040};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_ABCF,
                    {{4{16'h1357}}, {4{16'h2468}}, {4{16'h9ABC}}, {4{16'hDEF0}}}, 1, 32'h0000_ABC0};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF,
                    {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}}, 10, 32'hFFFF_FFE0};
        vecs[4] = '{1'b0, 1'b0, 32'h8000_005F,
                    {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 2, 32'h8000_0040};

        rst       = 1'b1;
        read_i    = 1'b0;
        write_i   = 1'b0;
        resp_i    = 1'b0;
        address_i = '0;
        line_i    = '0;
        burst_i   = '0;
        step();
        step();
        check_b("reset read_o", read_o, 1'b0);
        check_b("reset write_o", write_o, 1'b0);
        check_b("reset resp_o", resp_o, 1'b0);
        check_l("reset line_o", line_o, '0);
        check_w("reset address_o", address_o, 32'h0);
        check_stats("reset");

        // First table row is presented together with reset release.
        rst = 1'b0;
        foreach (vecs[i]) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].gap, vecs[i].both, vecs[i].exp_addr);
            else
                do_read(vecs[i].addr, vecs[i].data, vecs[i].gap, vecs[i].exp_addr);
        end
        check_w("table rd total", rd_count_o, STATS_EN ? 32'd3 : 32'd0);
        check_w("table wr total", wr_count_o, STATS_EN ? 32'd2 : 32'd0);

        // Reset after two beats of a read discards the partial line.
        read_i    = 1'b1;
        address_i = 32'h0000_2468;
        step();
        check_b("rstmid read_o up", read_o, 1'b1);
        step();
        resp_i  = 1'b1;
        burst_i = 64'hAAAA_0000_0000_0001;
        step();
        burst_i = 64'hAAAA_0000_0000_0002;
        step();
        resp_i = 1'b0;
        rst    = 1'b1;
        read_i = 1'b0;
        step();
        check_b("rstmid read_o", read_o, 1'b0);
        check_b("rstmid resp_o", resp_o, 1'b0);
        check_l("rstmid line_o", line_o, '0);
        check_w("rstmid address_o", address_o, 32'h0);
        exp_line = '0;
        exp_rd   = 0;
        exp_wr   = 0;
        check_stats("rstmid");
        rst = 1'b0;
        do_read(32'h0000_2468, {{16{4'h9}}, {16{4'hE}}, {16{4'h3}}, {16{4'h7}}}, 0, 32'h0000_2460);

        // Random traffic over a small address pool so reads return previously written lines.
        for (int t = 0; t < 24; t++) begin
            logic [31:0]       addr, a_exp;
            logic [LINE_W-1:0] data;
            int                gap;
            addr  = 32'h1000_0000 | ($urandom_range(0, 3) << 5) | $urandom_range(0, 31);
            a_exp = addr & AMASK;
            gap   = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                do_write(addr, rand_line(), gap, 1'($urandom_range(0, 1)), a_exp);
            end else begin
                data = mem.exists(a_exp) ? mem[a_exp] : rand_line();
                do_read(addr, data, gap, a_exp);
            end
        end
        check_stats("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
